mem_responder_wait: RTL
=======================

# mem_responder_wait

Single-port memory responder for the val/wait memory interface driven by the processor's imem and dmem ports. It services word reads and writes from an internal array and inserts a fixed, parameterized number of wait cycles per request. This lets the processor's stall logic be exercised against a real latency source rather than a zero-latency test memory. It also keeps a count of completed transactions for performance checks.

## Interface
- WORDS, 256, number of 32-bit words in the array; must be a power of two ≥ 4
- LATENCY, 2, number of cycles `mem_wait` is held high per request; 0–15 allowed
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- mem_val  input  1  request valid from requester
- mem_wait  output  1  responder not ready; requester must hold the request stable
- mem_type  input  1  0 = read, 1 = write
- mem_addr  input  32  byte address
- mem_wdata  input  32  write data
- mem_rdata  output  32  read data, meaningful only in the completion cycle of a read
- req_count  output  32  number of completed transactions

## Operation
- Index is `mem_addr[log2(WORDS)+1:2]`.
  - `mem_addr[1:0]` is ignored (word access only).
  - Upper address bits are ignored, so out-of-range addresses wrap modulo WORDS.
- A transaction completes in the cycle where `mem_val=1` and `mem_wait=0`.
  - Read: `mem_rdata = array[index]`, combinational from the current address.
  - Write: `array[index] <= mem_wdata` at the rising edge ending that cycle.
- `mem_rdata` = 0 in every cycle that is not a read completion.
- FSM states: IDLE, BUSY. 4-bit down-counter `cnt`.
  - LATENCY = 0: the FSM stays in IDLE; `mem_wait` = 0 always; every `mem_val` cycle is a completion.
  - IDLE, `mem_val=0`: `mem_wait=0`; stay in IDLE.
  - IDLE, `mem_val=1` (LATENCY>0): `mem_wait=1`; go to BUSY; `cnt <= LATENCY-1`.
  - BUSY, `mem_val=1`, `cnt≠0`: `mem_wait=1`; `cnt <= cnt-1`.
  - BUSY, `mem_val=1`, `cnt=0`: `mem_wait=0`; completion; go to IDLE.
  - BUSY, `mem_val=0` (requester dropped the request): abort; `mem_wait=0`; no write; `req_count` unchanged; go to IDLE.
- Requester changes to addr/type/wdata while `mem_wait=1` are a protocol violation. The responder uses whatever values are present in the completion cycle.
- `req_count` increments by 1 on each completion and wraps at 2^32.
- `mem_wait` is a function of state, `cnt` and `mem_val` only. It never depends on addr or data.

## Timing
- Reset (rst high at an edge): state IDLE, `cnt`=0, `req_count`=0.
  - During and after reset, `mem_wait`=0 and `mem_rdata`=0 while `mem_val=0`.
  - Array contents are not cleared by reset.
- `rst` asserted mid-transaction: aborts it, with no write and no count. The next cycle is IDLE.
- Latency: a request first presented in cycle n sees `mem_wait=1` for cycles n..n+LATENCY-1 and completes in cycle n+LATENCY.
- Back-to-back requests: the cycle after a completion is IDLE. A still-asserted `mem_val` is treated as a new request and pays the full LATENCY again. Sustained throughput is 1 transaction per LATENCY+1 cycles.
- Read-after-write to the same word in the next transaction returns the newly written data.
- A write and a read of the same word can never complete in the same cycle, because the block is single port.

## Test plan
- Reset behaviour: hold rst 2 cycles with `mem_val=1` → `mem_wait=0`, `mem_rdata=0`, `req_count=0` after release.
- LATENCY=0 write/read:
  - Write 0xdeadbeef to 0x100 → completes the same cycle.
  - Then read 0x100 → `mem_rdata=0xdeadbeef` the same cycle, `mem_wait` never high, `req_count=2`.
- LATENCY=2 read of 0x100 preloaded with 0x12345678: `mem_wait` high for exactly 2 cycles, then `mem_rdata=0x12345678` with `mem_wait=0` in the 3rd cycle, `req_count=1`.
- LATENCY=3, back-to-back write 0x0000abcd to 0x8 then read of 0x8 with `mem_val` held high: `mem_wait` pattern 1,1,1,0,1,1,1,0 → second completion returns 0x0000abcd.
- Abort:
  - LATENCY=3 write of 0x55 to 0x20, `mem_val` dropped after 1 wait cycle → no write, `req_count` unchanged.
  - Later read of 0x20 returns its old value.
  - Repeat with rst asserted mid-request instead → same result.
- Address wrap, WORDS=256: write 0xa5a5a5a5 to 0x404 → read of 0x004 returns 0xa5a5a5a5. Read of 0x006 (misaligned) returns the same word.

Source files
------------

// File: rtl/mem_responder_wait_if.sv
// Val/wait memory bus between a requester (master) and a responder (slave).
// A transfer completes in any cycle with mem_val=1 and mem_wait=0; while mem_wait=1 the master holds all request fields stable.
interface mem_responder_wait_if;
    logic        mem_val;
    logic        mem_wait;
    logic        mem_type;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport master (
        output mem_val, mem_type, mem_addr, mem_wdata,
        input  mem_wait, mem_rdata
    );

    modport slave (
        input  mem_val, mem_type, mem_addr, mem_wdata,
        output mem_wait, mem_rdata
    );
endinterface

// File: rtl/mem_responder_wait.sv
// Single-port word memory on the val/wait bus that inserts LATENCY wait cycles per request
// and counts completed transactions.
module mem_responder_wait #(
    parameter int WORDS   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_responder_wait_if.slave bus,
    output logic [31:0] req_count,
    output logic        dbg_busy
);
    localparam int AW = $clog2(WORDS);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] mem [WORDS];
    logic [AW-1:0] idx;
    logic        wait_c;
    logic        complete;
    logic        unused_addr_bits;

    assign idx              = bus.mem_addr[AW+1:2];
    assign unused_addr_bits = ^{bus.mem_addr[31:AW+2], bus.mem_addr[1:0]};
    assign dbg_busy         = (state == BUSY);

    // Wait depends only on state, cnt and mem_val; reset masks it so nothing completes under reset.
    always_comb begin
        wait_c = 1'b0;
        if (!rst && bus.mem_val && (LATENCY != 0))
            wait_c = (state == IDLE) || (cnt != 4'd0);
    end

    assign complete      = !rst && bus.mem_val && !wait_c;
    assign bus.mem_wait  = wait_c;
    assign bus.mem_rdata = (complete && !bus.mem_type) ? mem[idx] : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_count <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_val && (LATENCY != 0)) begin
                        state <= BUSY;
                        cnt   <= LAT_M1;
                    end
                end
                BUSY: begin
                    if (!bus.mem_val)
                        state <= IDLE;
                    else if (cnt != 4'd0)
                        cnt <= cnt - 4'd1;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (complete)
                req_count <= req_count + 32'd1;
        end
    end

    // Array is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (complete && bus.mem_type)
            mem[idx] <= bus.mem_wdata;
    end
endmodule
